rtc_time_reader: RTL and testbench

RTC_TIME_READER -- requirements
Module: rtc_time_reader

---
 rtl/rtc_time_reader.sv | 207 ++++++++++++++++++++
 tb/tb_rtc_time_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_reader.sv
// Periodic / on-demand reader of a BCD real-time clock over an external I2C master.
// Reads seconds, minutes and hours, validates the BCD and presents binary 24-hour time.
module rtc_time_reader #(
  parameter int         ClockFrequency = 1000000,
  parameter int         PollPeriodMs   = 1000,
  parameter logic [6:0] SlaveAddress   = 7'h68,
  parameter int         BusyAckTimeout = 4000,
  parameter int         MaxBytesToSend = 16,
  parameter int         MaxBytesToRead = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              refresh,
  output logic                              i2cStart,
  output logic [6:0]                        i2cAddress,
  output logic [$clog2(MaxBytesToSend):0]   i2cNrOfBytesToSend,
  output logic [MaxBytesToSend*8-1:0]       i2cBytesToSend,
  output logic [$clog2(MaxBytesToRead):0]   i2cNrOfBytesToRead,
  input  logic [MaxBytesToRead*8-1:0]       i2cBytesToRead,
  input  logic                              i2cReady,
  input  logic                              i2cClockStretchTimeoutReached,
  input  logic                              i2cNoAcknowledge,
  output logic [5:0]                        seconds,
  output logic [5:0]                        minutes,
  output logic [4:0]                        hours,
  output logic                              timeValid,
  output logic                              busy,
  output logic [7:0]                        errorCount
);

  localparam int PollTicks = PollPeriodMs * (ClockFrequency / 1000);
  localparam int PollW     = $clog2(PollTicks + 1);
  localparam int BusyW     = $clog2(BusyAckTimeout + 1);
  localparam int SendW     = $clog2(MaxBytesToSend) + 1;
  localparam int ReadW     = $clog2(MaxBytesToRead) + 1;

  typedef enum logic [2:0] {
    Idle,
    Request,
    WaitBusy,
    WaitDone,
    Decode
  } state_t;

  // Returns {valid, binary}; chk_b7 demands bit 7 be clear (minutes), seconds ignore it.
  function automatic logic [6:0] dec_min_sec(input logic [7:0] b, input logic chk_b7);
    logic       ok;
    logic [5:0] v;
    ok = (!b[7] || !chk_b7) && (b[6:4] <= 3'd5) && (b[3:0] <= 4'd9);
    v  = 6'(b[6:4]) * 6'd10 + 6'(b[3:0]);
    return {ok, v};
  endfunction

  // Returns {valid, binary 0..23}; bit 6 selects 12-hour mode with bit 5 as PM.
  function automatic logic [5:0] dec_hours(input logic [7:0] b);
    logic       ok;
    logic [4:0] v;
    logic [4:0] h12;
    h12 = 5'(b[4]) * 5'd10 + 5'(b[3:0]);
    if (!b[6]) begin
      v  = 5'(b[5:4]) * 5'd10 + 5'(b[3:0]);
      ok = !b[7] && (b[5:4] <= 2'd2) && (b[3:0] <= 4'd9) && (v <= 5'd23);
    end else begin
      ok = !b[7] && (b[3:0] <= 4'd9) && (h12 >= 5'd1) && (h12 <= 5'd12);
      if (b[5]) v = (h12 == 5'd12) ? 5'd12 : h12 + 5'd12;
      else      v = (h12 == 5'd12) ? 5'd0  : h12;
    end
    return {ok, v};
  endfunction

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic [5:0]      seconds_q, seconds_d;
  logic [5:0]      minutes_q, minutes_d;
  logic [4:0]      hours_q, hours_d;
  logic            valid_q, valid_d;
  logic [7:0]      err_q, err_d;

  logic            poll_tick;
  logic            error;
  logic [6:0]      sec_dec;
  logic [6:0]      min_dec;
  logic [5:0]      hr_dec;
  logic            unused_rd;

  // Data arrives first-byte-highest: [2] seconds, [1] minutes, [0] hours.
  assign sec_dec   = dec_min_sec(i2cBytesToRead[23:16], 1'b0);
  assign min_dec   = dec_min_sec(i2cBytesToRead[15:8], 1'b1);
  assign hr_dec    = dec_hours(i2cBytesToRead[7:0]);
  assign unused_rd = ^i2cBytesToRead[MaxBytesToRead*8-1:24];

  assign poll_tick = (poll_cnt_q == PollW'(PollTicks - 1));

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | refresh | poll_tick;
    poll_cnt_d = poll_tick ? '0 : poll_cnt_q + 1'b1;
    busy_cnt_d = busy_cnt_q;
    seconds_d  = seconds_q;
    minutes_d  = minutes_q;
    hours_d    = hours_q;
    valid_d    = valid_q;
    err_d      = err_q;
    error      = 1'b0;

    case (state_q)
      Idle: begin
        if (pending_q && i2cReady) state_d = Request;
      end
      Request: begin
        state_d    = WaitBusy;
        busy_cnt_d = '0;
      end
      WaitBusy: begin
        if (!i2cReady) begin
          state_d = WaitDone;
        end else if (busy_cnt_q == BusyW'(BusyAckTimeout - 1)) begin
          error   = 1'b1;
          state_d = Idle;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      WaitDone: begin
        if (i2cReady) begin
          if (i2cNoAcknowledge || i2cClockStretchTimeoutReached) begin
            error   = 1'b1;
            state_d = Idle;
          end else begin
            state_d = Decode;
          end
        end
      end
      Decode: begin
        state_d = Idle;
        if (sec_dec[6] && min_dec[6] && hr_dec[5]) begin
          seconds_d = sec_dec[5:0];
          minutes_d = min_dec[5:0];
          hours_d   = hr_dec[4:0];
          valid_d   = 1'b1;
        end else begin
          error = 1'b1;
        end
      end
      default: state_d = Idle;
    endcase

    // Starting a transaction consumes every request collected so far.
    if (state_q == Idle && state_d == Request) begin
      pending_d  = 1'b0;
      poll_cnt_d = '0;
    end

    if (error) begin
      valid_d = 1'b0;
      if (err_q != 8'hFF) err_d = err_q + 1'b1;
    end

    start_d = (state_d == Request);
    busy_d  = (state_d != Idle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= Idle;
      pending_q  <= 1'b1;
      poll_cnt_q <= '0;
      busy_cnt_q <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      seconds_q  <= '0;
      minutes_q  <= '0;
      hours_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      poll_cnt_q <= poll_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      seconds_q  <= seconds_d;
      minutes_q  <= minutes_d;
      hours_q    <= hours_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign i2cStart           = start_q;
  assign i2cAddress         = SlaveAddress;
  assign i2cNrOfBytesToSend = SendW'(1);
  assign i2cBytesToSend     = '0;
  assign i2cNrOfBytesToRead = ReadW'(3);
  assign seconds            = seconds_q;
  assign minutes            = minutes_q;
  assign hours              = hours_q;
  assign timeValid          = valid_q;
  assign busy               = busy_q;
  assign errorCount         = err_q;

endmodule

// File: tb/tb_rtc_time_reader.sv
// Bench for rtc_time_reader: behavioural I2C master, vector table and scoreboard of expected reads.
module tb_rtc_time_reader;

  localparam int CF  = 10000;
  localparam int PM  = 1000;
  localparam int BAT = 40;
  localparam int PT  = PM * (CF / 1000);

  logic         clock;
  logic         reset;
  logic         refresh;
  logic         i2cStart;
  logic [6:0]   i2cAddress;
  logic [4:0]   i2cNrOfBytesToSend;
  logic [127:0] i2cBytesToSend;
  logic [4:0]   i2cNrOfBytesToRead;
  logic [127:0] i2cBytesToRead;
  logic         i2cReady;
  logic         i2cClockStretchTimeoutReached;
  logic         i2cNoAcknowledge;
  logic [5:0]   seconds;
  logic [5:0]   minutes;
  logic [4:0]   hours;
  logic         timeValid;
  logic         busy;
  logic [7:0]   errorCount;

  rtc_time_reader #(
    .ClockFrequency(CF),
    .PollPeriodMs(PM),
    .SlaveAddress(7'h68),
    .BusyAckTimeout(BAT),
    .MaxBytesToSend(16),
    .MaxBytesToRead(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .refresh(refresh),
    .i2cStart(i2cStart),
    .i2cAddress(i2cAddress),
    .i2cNrOfBytesToSend(i2cNrOfBytesToSend),
    .i2cBytesToSend(i2cBytesToSend),
    .i2cNrOfBytesToRead(i2cNrOfBytesToRead),
    .i2cBytesToRead(i2cBytesToRead),
    .i2cReady(i2cReady),
    .i2cClockStretchTimeoutReached(i2cClockStretchTimeoutReached),
    .i2cNoAcknowledge(i2cNoAcknowledge),
    .seconds(seconds),
    .minutes(minutes),
    .hours(hours),
    .timeValid(timeValid),
    .busy(busy),
    .errorCount(errorCount)
  );

  typedef struct {
    logic [7:0] bs, bm, bh;
    bit         nack, str, ok;
    int         s, m, h;
  } vec_t;

  typedef struct {
    int s, m, h, v, e;
  } exp_t;

  vec_t vt[16];
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int exp_s = 0, exp_m = 0, exp_h = 0, exp_v = 0, exp_e = 0;

  logic [7:0] mdl_s, mdl_m, mdl_h;
  bit         mdl_nack, mdl_str, mdl_ignore, mdl_block;
  int         mdl_lat;
  int         mdl_starts;
  int         long_starts;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Behavioural I2C master: drops ready after a start, returns the configured bytes later.
  initial begin
    i2cReady = 1'b0;
    i2cNoAcknowledge = 1'b0;
    i2cClockStretchTimeoutReached = 1'b0;
    i2cBytesToRead = '0;
    mdl_starts = 0;
    long_starts = 0;
    forever begin
      @(negedge clock);
      if (i2cStart) begin
        mdl_starts++;
        if (!mdl_ignore) begin
          i2cReady = 1'b0;
          i2cNoAcknowledge = 1'b0;
          i2cClockStretchTimeoutReached = 1'b0;
        end
        @(negedge clock);
        if (i2cStart) long_starts++;
        if (!mdl_ignore) begin
          repeat (mdl_lat - 1) @(negedge clock);
          i2cBytesToRead = '0;
          i2cBytesToRead[23:0] = {mdl_s, mdl_m, mdl_h};
          i2cNoAcknowledge = mdl_nack;
          i2cClockStretchTimeoutReached = mdl_str;
          i2cReady = 1'b1;
        end
      end else begin
        i2cReady = !mdl_block;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input bit ok, input int s, input int m, input int h);
    if (ok) begin
      exp_s = s; exp_m = m; exp_h = h; exp_v = 1;
    end else begin
      exp_v = 0;
      exp_e = (exp_e < 255) ? exp_e + 1 : 255;
    end
    sb.push_back('{exp_s, exp_m, exp_h, exp_v, exp_e});
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int bound, output int w);
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!i2cStart && w < bound);
    chk({tag, "_start_seen"}, int'(i2cStart), 1);
  endtask

  task automatic wait_done(input string tag, input int bound, output int n);
    exp_t e;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < bound);
    chk({tag, "_done"}, int'(busy), 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      if (!busy) begin
        chk({tag, "_sec"}, int'(seconds), e.s);
        chk({tag, "_min"}, int'(minutes), e.m);
        chk({tag, "_hr"}, int'(hours), e.h);
        chk({tag, "_valid"}, int'(timeValid), e.v);
        chk({tag, "_errcnt"}, int'(errorCount), e.e);
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_start"}, int'(i2cStart), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(timeValid), 0);
    chk({tag, "_errcnt"}, int'(errorCount), 0);
    chk({tag, "_sec"}, int'(seconds), 0);
    chk({tag, "_min"}, int'(minutes), 0);
    chk({tag, "_hr"}, int'(hours), 0);
  endtask

  initial begin
    int w, n, n_last, starts0;

    vt[0]  = '{8'h59, 8'h34, 8'h12, 1'b0, 1'b0, 1'b1, 59, 34, 12};
    vt[1]  = '{8'h59, 8'h34, 8'h12, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vt[2]  = '{8'h5A, 8'h34, 8'h12, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vt[3]  = '{8'h00, 8'h00, 8'h72, 1'b0, 1'b0, 1'b1, 0, 0, 12};
    vt[4]  = '{8'h30, 8'h15, 8'h52, 1'b0, 1'b0, 1'b1, 30, 15, 0};
    vt[5]  = '{8'hD9, 8'h59, 8'h71, 1'b0, 1'b0, 1'b1, 59, 59, 23};
    vt[6]  = '{8'h01, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    vt[7]  = '{8'h10, 8'h80, 8'h10, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vt[8]  = '{8'h10, 8'h10, 8'h24, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vt[9]  = '{8'h00, 8'h00, 8'h23, 1'b0, 1'b0, 1'b1, 0, 0, 23};
    vt[10] = '{8'h00, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vt[11] = '{8'h00, 8'h00, 8'h53, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vt[12] = '{8'h00, 8'h60, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vt[13] = '{8'h00, 8'h00, 8'h1A, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vt[14] = '{8'h09, 8'h01, 8'h65, 1'b0, 1'b0, 1'b1, 9, 1, 17};
    vt[15] = '{8'h10, 8'h20, 8'h45, 1'b0, 1'b0, 1'b1, 10, 20, 5};

    reset = 1'b1;
    refresh = 1'b0;
    mdl_block = 1'b1;
    mdl_ignore = 1'b0;
    mdl_nack = 1'b0;
    mdl_str = 1'b0;
    mdl_lat = 3;
    mdl_s = 8'h00; mdl_m = 8'h00; mdl_h = 8'h00;

    repeat (3) @(negedge clock);
    chk_reset_state("por");
    chk("addr", int'(i2cAddress), 'h68);
    chk("nr_send", int'(i2cNrOfBytesToSend), 1);
    chk("nr_read", int'(i2cNrOfBytesToRead), 3);
    chk("send_bytes_zero", int'(i2cBytesToSend == '0), 1);
    reset = 1'b0;

    // Pending is set out of reset but the master is not ready yet.
    repeat (8) @(negedge clock);
    chk("no_start_ready_low", mdl_starts, 0);
    chk("idle_ready_low_busy", int'(busy), 0);

    for (int i = 0; i < 16; i++) begin
      mdl_s = vt[i].bs; mdl_m = vt[i].bm; mdl_h = vt[i].bh;
      mdl_nack = vt[i].nack; mdl_str = vt[i].str;
      starts0 = mdl_starts;
      push_exp(vt[i].ok, vt[i].s, vt[i].m, vt[i].h);
      if (i == 0) mdl_block = 1'b0;
      else pulse_refresh();
      wait_start($sformatf("vec%0d", i), 50, w);
      wait_done($sformatf("vec%0d", i), 200, n);
      chk($sformatf("vec%0d_starts", i), mdl_starts - starts0, 1);
    end

    // Master never acknowledges the start.
    mdl_ignore = 1'b1;
    mdl_nack = 1'b0; mdl_str = 1'b0;
    push_exp(1'b0, 0, 0, 0);
    pulse_refresh();
    wait_start("busy_to", 50, w);
    wait_done("busy_to", BAT + 50, n);
    chk("busy_to_cycles", n, BAT + 1);
    mdl_ignore = 1'b0;

    // Three refreshes while WaitDone collapse into one follow-up read.
    mdl_lat = 12;
    mdl_s = 8'h07; mdl_m = 8'h08; mdl_h = 8'h09;
    starts0 = mdl_starts;
    push_exp(1'b1, 7, 8, 9);
    push_exp(1'b1, 7, 8, 9);
    pulse_refresh();
    wait_start("merge3_a", 50, w);
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      pulse_refresh();
      @(negedge clock);
    end
    wait_done("merge3_a", 200, n);
    wait_start("merge3_b", 20, w);
    wait_done("merge3_b", 200, n);
    repeat (40) @(negedge clock);
    chk("merge3_starts", mdl_starts - starts0, 2);

    // Reset while WaitDone aborts at once; a new read follows once ready returns.
    mdl_lat = 20;
    mdl_s = 8'h21; mdl_m = 8'h43; mdl_h = 8'h13;
    push_exp(1'b1, 21, 43, 13);
    pulse_refresh();
    wait_start("rst_pre", 50, w);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_state("rst_wd");
    reset = 1'b0;
    sb.delete();
    exp_s = 0; exp_m = 0; exp_h = 0; exp_v = 0; exp_e = 0;
    push_exp(1'b1, 21, 43, 13);
    @(negedge clock);
    chk("rst_wait_ready_busy", int'(busy), 0);
    wait_start("rst_post", 60, w);
    wait_done("rst_post", 200, n);

    // 300 refused reads saturate the error counter.
    mdl_lat = 2;
    mdl_nack = 1'b1;
    n_last = 0;
    for (int k = 0; k < 300; k++) begin
      push_exp(1'b0, 0, 0, 0);
      pulse_refresh();
      wait_start($sformatf("sat%0d", k), 50, w);
      wait_done($sformatf("sat%0d", k), 100, n_last);
    end
    chk("sat_errcnt", int'(errorCount), 255);
    mdl_nack = 1'b0;

    // Refresh lands in the same cycle as the poll tick, then the next tick alone.
    mdl_s = 8'h45; mdl_m = 8'h32; mdl_h = 8'h21;
    starts0 = mdl_starts;
    push_exp(1'b1, 45, 32, 21);
    repeat (PT - 1 - n_last) @(negedge clock);
    pulse_refresh();
    wait_start("tick_merge", 20, w);
    chk("tick_merge_delay", w, 1);
    wait_done("tick_merge", 100, n);
    push_exp(1'b1, 45, 32, 21);
    wait_start("poll_auto", PT + 50, w);
    chk("poll_period", n + w, PT + 1);
    wait_done("poll_auto", 100, n);
    chk("tick_starts", mdl_starts - starts0, 2);

    chk("start_one_cycle", long_starts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
